hs_elastic_fifo: RTL

Elastic buffer for the req/ack dataflow handshake, placed directly downstream of a dataflow graph's `out` operator and upstream of the bench consumer or a following graph. It pulls items from the graph output and re-offers them downstream with the same one-cycle-ack protocol. It decouples consumer stalls from the graph, so a graph stall only occurs when the buffer is full.

---
 rtl/hs_pkg.sv | 25 ++
 rtl/hs_elastic_fifo_if.sv | 40 ++++
 rtl/hs_fifo_mem.sv | 29 ++
 rtl/hs_elastic_fifo.sv | 117 +++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared handshake definitions: default sizing, width helpers and the
// req/ack/data bundle type used by producer/consumer models and wrappers.
package hs_pkg;

    localparam int unsigned HS_DATA_WIDTH = 32'd32;
    localparam int unsigned HS_DEPTH      = 32'd4;

    function automatic int unsigned hs_ptr_width(input int unsigned d);
        return (d > 32'd1) ? $clog2(d) : 32'd1;
    endfunction

    function automatic int unsigned hs_level_width(input int unsigned d);
        return $clog2(d) + 32'd1;
    endfunction

    localparam int unsigned HS_PTR_W = hs_ptr_width(HS_DEPTH);
    localparam int unsigned HS_LVL_W = hs_level_width(HS_DEPTH);

    typedef struct packed {
        logic                     req;
        logic                     ack;
        logic [HS_DATA_WIDTH-1:0] data;
    } hs_port_t;

endpackage

// File: rtl/hs_elastic_fifo_if.sv
// Upstream/downstream handshake bundle of the elastic FIFO plus its status.
interface hs_elastic_fifo_if
    import hs_pkg::*;
#(
    parameter int unsigned data_width = HS_DATA_WIDTH,
    parameter int unsigned depth      = HS_DEPTH
);

    logic                                 in_req;
    logic                                 in_ack;
    logic [data_width-1:0]                in_data;
    logic                                 out_req;
    logic                                 out_ack;
    logic [data_width-1:0]                out_data;
    logic [hs_level_width(depth)-1:0]     level;
    logic                                 overflow;

    modport master (
        output in_req,
        input  in_ack,
        input  in_data,
        input  out_req,
        output out_ack,
        output out_data,
        output level,
        output overflow
    );

    modport slave (
        input  in_req,
        output in_ack,
        output in_data,
        output out_req,
        input  out_ack,
        input  out_data,
        input  level,
        input  overflow
    );

endinterface

// File: rtl/hs_fifo_mem.sv
// Register-array storage for the elastic FIFO: one write port, one
// combinational read port, no reset on the contents.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter  int unsigned data_width = HS_DATA_WIDTH,
    parameter  int unsigned depth      = HS_DEPTH,
    localparam int unsigned aw         = hs_ptr_width(depth)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [aw-1:0]         waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic [aw-1:0]         raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [depth];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_elastic_fifo.sv
// Elastic buffer between a dataflow graph output and its consumer; re-offers
// items downstream with the one-cycle-ack protocol.
module hs_elastic_fifo
    import hs_pkg::*;
#(
    parameter int unsigned data_width = HS_DATA_WIDTH,
    parameter int unsigned depth      = HS_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    hs_elastic_fifo_if.master      bus
);

    localparam int unsigned PW = hs_ptr_width(depth);
    localparam int unsigned LW = hs_level_width(depth);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(1'b0);
    localparam logic [LW-1:0] LVL_FULL = LW'(depth);
    // Leaves one free slot for an ack already in flight when the request drops.
    localparam logic [LW-1:0] LVL_REQ  = LW'(depth - 32'd2);

    logic [PW-1:0]         wp_q, wp_d;
    logic [PW-1:0]         rp_q, rp_d;
    logic [LW-1:0]         count_q, count_d;
    logic                  in_req_q, in_req_d;
    logic                  out_ack_q, out_ack_d;
    logic                  overflow_q, overflow_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic [data_width-1:0] rd_data_s;
    logic                  full_s, empty_s, push_s, pop_s;

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wp_q),
        .wdata_i (bus.in_data),
        .raddr_i (rp_q),
        .rdata_o (rd_data_s)
    );

    // Next-state logic for pointers, occupancy and both handshake sides
    always_comb begin
        full_s     = (count_q == LVL_FULL);
        empty_s    = (count_q == LVL_ZERO);
        push_s     = bus.in_ack & ~full_s;
        pop_s      = bus.out_req & ~out_ack_q & ~empty_s;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        out_ack_d  = 1'b0;
        out_data_d = out_data_q;

        if (push_s) begin
            wp_d = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end

        if (bus.in_ack & full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        if (pop_s) begin
            rp_d       = rp_q + PTR_ONE;
            out_ack_d  = 1'b1;
            out_data_d = rd_data_s;
        end else begin
            rp_d       = rp_q;
            out_ack_d  = 1'b0;
            out_data_d = out_data_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_ONE;
            2'b01:   count_d = count_q - LVL_ONE;
            default: count_d = count_q;
        endcase

        in_req_d = (count_d <= LVL_REQ);
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            in_req_q   <= 1'b0;
            out_ack_q  <= 1'b0;
            overflow_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            in_req_q   <= in_req_d;
            out_ack_q  <= out_ack_d;
            overflow_q <= overflow_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.in_req   = in_req_q;
    assign bus.out_ack  = out_ack_q;
    assign bus.out_data = out_data_q;
    assign bus.level    = count_q;
    assign bus.overflow = overflow_q;

endmodule
